// File: rtl/float_sub_seq_if.sv
// Operand/result handshake bundle for float_sub_seq.
// The op select exists only when FSUB_ADD_MODE_EN is defined.
interface float_sub_seq_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] result;
    logic         out_valid;
    logic         out_ready;
    logic         overflow;
    logic         underflow;
`ifdef FSUB_ADD_MODE_EN
    logic         op;

    modport master (
        output a, b, op, in_valid, out_ready,
        input  in_ready, result, out_valid, overflow, underflow
    );
    modport slave (
        input  a, b, op, in_valid, out_ready,
        output in_ready, result, out_valid, overflow, underflow
    );
`else
    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, result, out_valid, overflow, underflow
    );
    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, result, out_valid, overflow, underflow
    );
`endif
endinterface

// File: rtl/float_sub_seq.sv
// Multi-cycle single-precision subtractor (a - b, truncating, no denormals).
// Define FSUB_ADD_MODE_EN to add the op input selecting a + b (op=1) or a - b (op=0).
module float_sub_seq #(
    parameter int EXP_W     = 8,
    parameter int FRAC_W    = 23,
    parameter int ALIGN_MAX = FRAC_W + 2
) (
    input  logic           clk,
    input  logic           rst,
    float_sub_seq_if.slave bus
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int MW = FRAC_W + 2;
    localparam logic [EXP_W-1:0] EXP_MAX   = '1;
    localparam logic [EXP_W-1:0] ALIGN_LIM = EXP_W'(ALIGN_MAX);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        ALIGN  = 3'd2,
        ADD    = 3'd3,
        NORM   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]     opa_q, opa_d;
    logic [W-1:0]     opb_q, opb_d;
    logic             sign_x_q, sign_x_d;
    logic             sign_y_q, sign_y_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [EXP_W-1:0] diff_q, diff_d;
    logic [MW-1:0]    mant_x_q, mant_x_d;
    logic [MW-1:0]    mant_y_q, mant_y_d;
    logic [MW-1:0]    sum_q, sum_d;
    logic [W-1:0]     result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             sub_sign;
    logic [EXP_W-1:0] exp_a, exp_b, exp_gap, exp_inc, exp_dec;
    logic [MW-1:0]    mant_a, mant_b;
    logic             a_ge_b;

    function automatic logic [W-1:0] pack(input logic s, input logic [EXP_W-1:0] e,
                                          input logic [FRAC_W-1:0] f);
        return {s, e, f};
    endfunction

    function automatic logic [W-1:0] sat_inf(input logic s);
        return {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    endfunction

`ifdef FSUB_ADD_MODE_EN
    assign sub_sign = ~bus.op;
`else
    assign sub_sign = 1'b1;
`endif

    // A zero exponent means the whole operand is zero, fraction bits included.
    assign exp_a  = opa_q[W-2 -: EXP_W];
    assign exp_b  = opb_q[W-2 -: EXP_W];
    assign mant_a = (exp_a == '0) ? '0 : {1'b0, 1'b1, opa_q[FRAC_W-1:0]};
    assign mant_b = (exp_b == '0) ? '0 : {1'b0, 1'b1, opb_q[FRAC_W-1:0]};
    assign a_ge_b = (exp_a > exp_b) || ((exp_a == exp_b) && (mant_a >= mant_b));
    assign exp_gap = a_ge_b ? (exp_a - exp_b) : (exp_b - exp_a);
    assign exp_inc = exp_q + 1'b1;
    assign exp_dec = exp_q - 1'b1;

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sign_x_d = sign_x_q;
        sign_y_d = sign_y_q;
        exp_d    = exp_q;
        diff_d   = diff_q;
        mant_x_d = mant_x_q;
        mant_y_d = mant_y_q;
        sum_d    = sum_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    opa_d   = bus.a;
                    opb_d   = {bus.b[W-1] ^ sub_sign, bus.b[W-2:0]};
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                if (a_ge_b) begin
                    sign_x_d = opa_q[W-1];
                    sign_y_d = opb_q[W-1];
                    exp_d    = exp_a;
                    mant_x_d = mant_a;
                    mant_y_d = mant_b;
                end else begin
                    sign_x_d = opb_q[W-1];
                    sign_y_d = opa_q[W-1];
                    exp_d    = exp_b;
                    mant_x_d = mant_b;
                    mant_y_d = mant_a;
                end
                // Beyond ALIGN_MAX every bit of Y would be shifted out anyway.
                if (exp_gap >= ALIGN_LIM) begin
                    mant_y_d = '0;
                    diff_d   = '0;
                end else begin
                    diff_d   = exp_gap;
                end
                state_d = (diff_d == '0) ? ADD : ALIGN;
            end
            ALIGN: begin
                mant_y_d = mant_y_q >> 1;
                diff_d   = diff_q - 1'b1;
                if (diff_q == EXP_W'(1)) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                if (sign_x_q == sign_y_q) begin
                    sum_d = mant_x_q + mant_y_q;
                end else begin
                    sum_d = mant_x_q - mant_y_q;
                end
                state_d = NORM;
            end
            NORM: begin
                if (sum_q == '0) begin
                    result_d = '0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    state_d  = DONE;
                end else if (sum_q[MW-1]) begin
                    sum_d   = sum_q >> 1;
                    exp_d   = exp_inc;
                    unf_d   = 1'b0;
                    state_d = DONE;
                    if (exp_inc == EXP_MAX) begin
                        result_d = sat_inf(sign_x_q);
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = pack(sign_x_q, exp_inc, sum_d[FRAC_W-1:0]);
                        ovf_d    = 1'b0;
                    end
                end else if (!sum_q[MW-2]) begin
                    // The shift that lands the leading one on the hidden bit also packs.
                    sum_d = sum_q << 1;
                    exp_d = exp_dec;
                    if (exp_dec == '0) begin
                        result_d = '0;
                        ovf_d    = 1'b0;
                        unf_d    = 1'b1;
                        state_d  = DONE;
                    end else if (sum_q[MW-3]) begin
                        result_d = pack(sign_x_q, exp_dec, sum_d[FRAC_W-1:0]);
                        ovf_d    = 1'b0;
                        unf_d    = 1'b0;
                        state_d  = DONE;
                    end
                end else begin
                    result_d = pack(sign_x_q, exp_q, sum_q[FRAC_W-1:0]);
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Working registers carry no reset: they are always rewritten before use.
    always_ff @(posedge clk) begin
        opa_q    <= opa_d;
        opb_q    <= opb_d;
        sign_x_q <= sign_x_d;
        sign_y_q <= sign_y_d;
        exp_q    <= exp_d;
        diff_q   <= diff_d;
        mant_x_q <= mant_x_d;
        mant_y_q <= mant_y_d;
        sum_q    <= sum_d;
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_float_sub_seq.sv
// Bench for float_sub_seq: directed corner cases, abort-by-reset, then random
// operands checked against an integer-arithmetic reference of the subtract rules.
module tb_float_sub_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    float_sub_seq_if bus_if();

    float_sub_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks   = 0;
    int failures = 0;

`ifdef FSUB_ADD_MODE_EN
    initial bus_if.op = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    // Reference: value-level arithmetic on integer mantissas.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic ovf,
                                  output logic unf, output int lat);
        int     ea, eb, ex, k, n;
        longint ma, mb, mx, my, s;
        logic   sa, sb, sx, sy;
        sa = a[31];
        sb = ~b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = (ea == 0) ? 0 : (longint'(a[22:0]) + 64'd8388608);
        mb = (eb == 0) ? 0 : (longint'(b[22:0]) + 64'd8388608);
        if (longint'(ea) * 16777216 + ma >= longint'(eb) * 16777216 + mb) begin
            ex = ea; sx = sa; sy = sb; mx = ma; my = mb; k = ea - eb;
        end else begin
            ex = eb; sx = sb; sy = sa; mx = mb; my = ma; k = eb - ea;
        end
        if (k >= 25) begin
            my = 0;
            k  = 0;
        end
        my  = my >> k;
        s   = (sx == sy) ? mx + my : mx - my;
        ovf = 1'b0;
        unf = 1'b0;
        n   = 0;
        if (s == 0) begin
            res = 32'h0;
        end else if (s >= 64'd16777216) begin
            s = s >> 1;
            ex++;
            n = 1;
            if (ex == 255) begin
                ovf = 1'b1;
                res = {sx, 8'hFF, 23'h0};
            end else begin
                res = {sx, 8'(ex), s[22:0]};
            end
        end else begin
            while (s < 64'd8388608) begin
                s = s << 1;
                ex--;
                n++;
                if (ex == 0) break;
            end
            if (ex == 0) begin
                unf = 1'b1;
                res = 32'h0;
            end else begin
                res = {sx, 8'(ex), s[22:0]};
            end
        end
        lat = 3 + k + ((n > 1) ? n : 1);
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic eo, input logic eu,
                          input int el, input int stall, input string tag);
        int lat;
        logic [31:0] held;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(bus_if.in_ready), 32'd1);
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        lat = 1;
        while (!bus_if.out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(el));
        chk({tag, ".result"}, bus_if.result, er);
        chk({tag, ".overflow"}, 32'(bus_if.overflow), 32'(eo));
        chk({tag, ".underflow"}, 32'(bus_if.underflow), 32'(eu));
        held = bus_if.result;
        repeat (stall) begin
            @(posedge clk);
            #1;
            chk({tag, ".stall_result"}, bus_if.result, held);
            chk({tag, ".stall_vld_rdy"}, {30'd0, bus_if.out_valid, bus_if.in_ready}, 32'd2);
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        chk({tag, ".release"}, {30'd0, bus_if.out_valid, bus_if.in_ready}, 32'd1);
    endtask

    task automatic run_rand(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] er;
        logic eo, eu;
        int el;
        model(a, b, er, eo, eu, el);
        run_op(a, b, er, eo, eu, el, 0, tag);
    endtask

    function automatic logic [31:0] rnd_fp(input int e_lo, input int e_hi);
        logic [7:0] e;
        e = 8'($urandom_range(e_hi, e_lo));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        logic [31:0] ra, rb;
        int eb_i;
        logic seen;
        bus_if.a = '0;
        bus_if.b = '0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;

        #12;
        chk("reset.in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("reset.out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("reset.result", bus_if.result, 32'h0);
        chk("reset.flags", {30'd0, bus_if.overflow, bus_if.underflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h40400000, 32'h3F800000, 32'h40000000, 0, 0, 5, 5, "three_minus_one");
        run_op(32'h3F800000, 32'h3F800000, 32'h00000000, 0, 0, 4, 0, "cancel");
        run_op(32'h3F800000, 32'hBF800000, 32'h40000000, 0, 0, 4, 0, "carry");
        run_op(32'h3F800001, 32'h3F800000, 32'h34000000, 0, 0, 26, 0, "max_renorm");
        run_op(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1, 0, 4, 0, "overflow");
        run_op(32'h00800001, 32'h00800000, 32'h00000000, 0, 1, 4, 0, "underflow");
        run_op(32'h3F800000, 32'h337FFFFF, 32'h3F800000, 0, 0, 4, 0, "gap25_clear");
        run_op(32'h3F800000, 32'h33FFFFFF, 32'h3F800000, 0, 0, 28, 0, "gap24_shift");
        run_op(32'h3F800000, 32'h347FFFFF, 32'h3F7FFFFE, 0, 0, 27, 0, "gap23_borrow");
        run_op(32'h3F800000, 32'h40400000, 32'hC0000000, 0, 0, 5, 0, "swap_neg");

        // Abort during ALIGN: exponent gap 20 keeps the block shifting for a while.
        @(negedge clk);
        bus_if.a = 32'h49800000;
        bus_if.b = 32'h3F800000;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort.out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("abort.in_ready", 32'(bus_if.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            seen = seen | bus_if.out_valid;
        end
        chk("abort.no_output", 32'(seen), 32'd0);
        run_op(32'h40400000, 32'h3F800000, 32'h40000000, 0, 0, 5, 0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            ra = rnd_fp(1, 254);
            case (i % 4)
                0: rb = rnd_fp(1, 254);
                1: begin
                    eb_i = int'(ra[30:23]) + int'($urandom_range(6, 0)) - 3;
                    if (eb_i < 1) eb_i = 1;
                    if (eb_i > 254) eb_i = 254;
                    rb = {1'($urandom), 8'(eb_i), 23'($urandom)};
                end
                2: rb = {1'($urandom), ra[30:0]};
                default: rb = ($urandom_range(1, 0) == 1) ? 32'h0 : rnd_fp(100, 150);
            endcase
            run_rand(ra, rb, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/float_sub_seq.md
Name: float_sub_seq

Overview:
- Multi-cycle IEEE-754 single-precision subtractor: computes Result = a - b.
- It is the inverse-operation companion of the team's combinational float adder.
- Unlike the adder, it handles mixed signs, magnitude ordering, and full renormalisation by left shift.
- It sits behind a valid/ready handshake so the datapath can be shared and stalled.

Parameters:
- EXP_W, 8, exponent width.
- FRAC_W, 23, stored fraction width. Mantissa width is FRAC_W+1 with the hidden bit.
- ALIGN_MAX, FRAC_W+2, exponent difference at or above which the smaller operand is cleared to zero.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous and active-high
- a  input  32  minuend
- b  input  32  subtrahend
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- result  output  32  a - b, truncated
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- overflow  output  1  result saturated to infinity; valid with out_valid
- underflow  output  1  result flushed to zero; valid with out_valid

Behaviour:
- Reset, asynchronous and active-high:
  - state IDLE; in_ready=1; out_valid=0; result, overflow, underflow = 0.
  - Assertion mid-operation aborts the operation immediately; no output is produced for it.
- FSM states: IDLE, UNPACK, ALIGN, ADD, NORM, DONE.
- IDLE:
  - in_ready=1.
  - on in_valid & in_ready at edge T: latch a and b with b's sign inverted; go to UNPACK.
- UNPACK (1 cycle):
  - mant = {exp!=0, frac} (25-bit working register, bit 24 = carry). exp==0 means the operand is zero (no denormals).
  - Swap so that X has the larger magnitude, compared by exponent then mantissa.
  - diff = expX - expY. If diff >= ALIGN_MAX, clear Y mantissa and set diff=0.
- ALIGN (k = diff cycles; skipped when k=0):
  - Shift mantY right 1 bit per cycle and decrement diff; exit when diff==0.
  - No guard bits; truncation only.
- ADD (1 cycle):
  - Signs equal: sum = mantX + mantY. Signs differ: sum = mantX - mantY (never negative).
  - Result sign = sign of X.
- NORM (max(1,n) cycles, one action per cycle):
  - sum==0: result +0 (0x00000000), go to DONE.
  - sum[24]==1: shift right 1, exp+1. If exp reaches 255: result {sign,0xFF,0}, overflow=1, go to DONE.
  - sum[23]==0: shift left 1, exp-1. If exp reaches 0: result +0, underflow=1, go to DONE.
  - Otherwise pack {sign, exp, sum[22:0]} and go to DONE.
- DONE:
  - out_valid=1; result and flags held stable while out_ready=0.
  - On out_valid & out_ready: go to IDLE. in_ready=1 in the following cycle.
- Latency: out_valid first high in cycle T+3+k+max(1,n).
- Throughput: one operation in flight; in_ready=0 from UNPACK through DONE.
- Exact cancellation, i.e. equal magnitudes with differing effective signs, always gives +0.
- Operands with exponent 255 (inf/NaN) are treated as normal numbers. Their behaviour is undefined and is not checked.

Optional Feature:
- Macro: FSUB_ADD_MODE_EN.
- When defined:
  - Adds input port op (1 bit), latched with the operands on acceptance.
  - op=1 computes a + b (b's sign is not inverted); op=0 computes a - b.
- When undefined:
  - Port op is absent; the block always subtracts.

Test Plan:
- 3.0 - 1.0: a=0x40400000, b=0x3F800000 → result=0x40000000, flags 0, out_valid at T+5 (k=1, n=0).
- 1.0 - 1.0: a=b=0x3F800000 → result=0x00000000, out_valid at T+4.
- 1.0 - (-1.0): a=0x3F800000, b=0xBF800000 → result=0x40000000 via carry path, out_valid at T+4.
- Maximum renormalisation: a=0x3F800001, b=0x3F800000 → result=0x34000000 after 23 left shifts, out_valid at T+26.
- Overflow: a=0x7F7FFFFF, b=0xFF7FFFFF → result=0x7F800000, overflow=1.
- Handshake and reset:
  - out_ready held low 5 cycles in DONE → result and out_valid stable, in_ready=0.
  - rst pulsed during ALIGN → IDLE immediately, out_valid=0, in_ready=1.
